// File: rtl/stall_controller_if.sv
// rtl/stall_controller_if.sv - hazard inputs and per-stage enable/bubble bundle for the stall controller
interface stall_controller_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] rsID;
    logic [REG_ADDR_WIDTH-1:0] rtID;
    logic                      useRtID;
    logic                      memReadEX;
    logic [REG_ADDR_WIDTH-1:0] rtEX;
    logic                      branchTakenEX;
    logic                      muldivStartEX;
    logic                      memRequestMEM;
    logic                      memReadyMEM;

    logic enablePC;
    logic enableIFID;
    logic enableIDEX;
    logic enableEXMEM;
    logic enableMEMWB;
    logic bubbleIFID;
    logic bubbleIDEX;
    logic bubbleEXMEM;
    logic bubbleMEMWB;
    logic muldivDone;

    modport master (
        output rsID, rtID, useRtID, memReadEX, rtEX, branchTakenEX,
               muldivStartEX, memRequestMEM, memReadyMEM,
        input  enablePC, enableIFID, enableIDEX, enableEXMEM, enableMEMWB,
               bubbleIFID, bubbleIDEX, bubbleEXMEM, bubbleMEMWB, muldivDone
    );

    modport slave (
        input  rsID, rtID, useRtID, memReadEX, rtEX, branchTakenEX,
               muldivStartEX, memRequestMEM, memReadyMEM,
        output enablePC, enableIFID, enableIDEX, enableEXMEM, enableMEMWB,
               bubbleIFID, bubbleIDEX, bubbleEXMEM, bubbleMEMWB, muldivDone
    );
endinterface

// File: rtl/stall_controller.sv
// rtl/stall_controller.sv - 5-stage pipeline stall/flush sequencer with mult/div occupancy and stall counter
module stall_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clock,
    input  logic                   resetStallController,
    stall_controller_if.slave      bus,
    output logic                   busyStallController,
    output logic [COUNT_WIDTH-1:0] stallCycles
);
    localparam int CNT_W = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 2);

    typedef enum logic {RUN, BUSY} state_t;

    state_t                    state, state_next;
    logic [CNT_W-1:0]          count, count_next;
    logic [REG_ADDR_WIDTH-1:0] rs_id, rt_id, rt_ex;
    logic                      mem_stall, load_use;
    // en: {PC, IFID, IDEX, EXMEM, MEMWB}; bub: {IFID, IDEX, EXMEM, MEMWB}
    logic [4:0]                en;
    logic [3:0]                bub;
    logic                      done;

    assign rs_id = bus.rsID;
    assign rt_id = bus.rtID;
    assign rt_ex = bus.rtEX;

    assign mem_stall = bus.memRequestMEM & ~bus.memReadyMEM;
    assign load_use  = bus.memReadEX & (rt_ex != '0) &
                       ((rt_ex == rs_id) | (bus.useRtID & (rt_ex == rt_id)));

    always_comb begin
        state_next = state;
        count_next = count;
        en         = 5'b11111;
        bub        = 4'b0000;
        done       = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    en  = 5'b00001;
                    bub = 4'b0001;
                end else if (bus.branchTakenEX) begin
                    bub = 4'b1100;
                end else if (bus.muldivStartEX) begin
                    en         = 5'b00001;
                    bub        = 4'b0010;
                    count_next = CNT_LOAD;
                    state_next = BUSY;
                end else if (load_use) begin
                    en  = 5'b00111;
                    bub = 4'b0100;
                end
            end
            BUSY: begin
                if (mem_stall) begin
                    en  = 5'b00001;
                    bub = 4'b0001;
                end else if (count != '0) begin
                    en         = 5'b00001;
                    bub        = 4'b0010;
                    count_next = count - 1'b1;
                end else begin
                    done       = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge resetStallController) begin
        if (resetStallController) begin
            state       <= RUN;
            count       <= '0;
            stallCycles <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (!en[4] && (stallCycles != '1))
                stallCycles <= stallCycles + 1'b1;
        end
    end

    // Reset must silence the datapath controls even before the state register settles.
    assign bus.enablePC    = en[4]  & ~resetStallController;
    assign bus.enableIFID  = en[3]  & ~resetStallController;
    assign bus.enableIDEX  = en[2]  & ~resetStallController;
    assign bus.enableEXMEM = en[1]  & ~resetStallController;
    assign bus.enableMEMWB = en[0]  & ~resetStallController;
    assign bus.bubbleIFID  = bub[3] & ~resetStallController;
    assign bus.bubbleIDEX  = bub[2] & ~resetStallController;
    assign bus.bubbleEXMEM = bub[1] & ~resetStallController;
    assign bus.bubbleMEMWB = bub[0] & ~resetStallController;
    assign bus.muldivDone  = done   & ~resetStallController;

    assign busyStallController = (state == BUSY);
endmodule
